// File: rtl/hazard_ctrl.sv
// Pipeline sequencing: register enables/clears, load-use and branch hazards, E-stage forwarding.
// Latency: enables, clears and forwards are combinational; FSM state and perf counters are registered.
// Backpressure: an outstanding I$/D$ miss freezes every pipeline register until its fill pulse arrives.
module hazard_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            Rs1D,
    input  logic [4:0]            Rs2D,
    input  logic [4:0]            Rs1E,
    input  logic [4:0]            Rs2E,
    input  logic [4:0]            RdE,
    input  logic [4:0]            RdM,
    input  logic [4:0]            RdW,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  ResultSrcE0,
    input  logic                  PCSrcE,
    input  logic                  imiss_f,
    input  logic                  imem_ready,
    input  logic                  dmiss_m,
    input  logic                  dmem_ready,
    output logic                  EnF,
    output logic                  EnD,
    output logic                  EnE,
    output logic                  EnM,
    output logic                  EnW,
    output logic                  ClrD,
    output logic                  ClrE,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic [DATA_WIDTH-1:0] stall_cycles,
    output logic [DATA_WIDTH-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALL_D = 2'd1,
        STALL_I = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
    logic [DATA_WIDTH-1:0] flush_count_q, flush_count_d;
    logic                  freeze;
    logic                  load_use;
    logic                  flush;

    // Hazard detection; a miss seen in RUN freezes the same cycle so the missing instruction holds
    always_comb begin
        freeze   = (state_q != RUN) || dmiss_m || imiss_f;
        load_use = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
        flush    = rst_n && !freeze && PCSrcE;
    end

    // Miss FSM: a data miss is served first; imiss is re-sampled only on the data fill cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (dmiss_m)      state_d = STALL_D;
                else if (imiss_f) state_d = STALL_I;
            end
            STALL_D: begin
                if (dmem_ready)   state_d = imiss_f ? STALL_I : RUN;
            end
            STALL_I: begin
                if (imem_ready)   state_d = RUN;
            end
            default:              state_d = RUN;
        endcase
    end

    // Enables and clears: freeze beats flush, flush beats load-use bubble
    always_comb begin
        EnF  = 1'b0;
        EnD  = 1'b0;
        EnE  = 1'b0;
        EnM  = 1'b0;
        EnW  = 1'b0;
        ClrD = 1'b0;
        ClrE = 1'b0;
        if (rst_n && !freeze) begin
            EnE = 1'b1;
            EnM = 1'b1;
            EnW = 1'b1;
            if (PCSrcE) begin
                EnF  = 1'b1;
                EnD  = 1'b1;
                ClrD = 1'b1;
                ClrE = 1'b1;
            end else if (load_use) begin
                ClrE = 1'b1;
            end else begin
                EnF = 1'b1;
                EnD = 1'b1;
            end
        end
    end

    // Operand forwarding: the younger producer in M wins over W; x0 is never forwarded
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (rst_n) begin
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
        end
    end

    // Performance counters, wrapping naturally at the counter width
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!EnF) stall_cycles_d = stall_cycles_q + 1'b1;
        if (flush) flush_count_d = flush_count_q + 1'b1;
    end

    // State and counter registers; reset drops any pending miss
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: table of RUN-state vectors, hand sequences for miss/reset timing, random run vs model.
// Latency: outputs sampled 2 time units after each rising edge; counters compared against edges elapsed.
// Backpressure: bench plays both caches, holding each miss high until its fill pulse.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW, ResultSrcE0, PCSrcE;
    logic        imiss_f, imem_ready, dmiss_m, dmem_ready;
    logic        EnF, EnD, EnE, EnM, EnW, ClrD, ClrE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] stall_cycles, flush_count;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .imiss_f(imiss_f), .imem_ready(imem_ready),
        .dmiss_m(dmiss_m), .dmem_ready(dmem_ready),
        .EnF(EnF), .EnD(EnD), .EnE(EnE), .EnM(EnM), .EnW(EnW),
        .ClrD(ClrD), .ClrE(ClrE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwm, rww, lde, br;
        logic [4:0] en;
        logic [1:0] clr, fa, fb;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] en_bus();
        return {EnF, EnD, EnE, EnM, EnW};
    endfunction

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteM, RegWriteW, ResultSrcE0, PCSrcE} = '0;
        {imiss_f, imem_ready, dmiss_m, dmem_ready} = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One cache port: holds miss for a random time, pulses ready, drops miss the next cycle
    task automatic cache_step(inout bit on, inout bit done, inout int cnt,
                              output logic miss, output logic rdy);
        if (done) begin
            miss = 1'b0; rdy = 1'b0; on = 1'b0; done = 1'b0;
        end else if (on) begin
            miss = 1'b1;
            if (cnt == 0) begin rdy = 1'b1; done = 1'b1; end
            else begin rdy = 1'b0; cnt--; end
        end else if ($urandom_range(0, 7) == 0) begin
            on = 1'b1; miss = 1'b1; rdy = 1'b0; cnt = $urandom_range(0, 4);
        end else begin
            miss = 1'b0; rdy = ($urandom_range(0, 15) == 0);
        end
    endtask

    function automatic logic [1:0] fsel(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    initial begin
        logic [31:0] sc, fc;
        bit          wq[$];          // fills being waited for, oldest first; 1 = data, 0 = instruction
        int unsigned m_stall, m_flush;
        bit          d_on, d_done, i_on, i_done;
        int          d_cnt, i_cnt;
        bit          frozen, lu;
        logic [4:0]  exp_en;
        logic [1:0]  exp_clr;

        //            rs1d rs2d rs1e rs2e rde rdm rdw rwm rww lde br   en        clr    fa     fb
        vt[0]  = '{0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 5'b11111, 2'b00, 2'b00, 2'b00};
        vt[1]  = '{5,  0,  0,  0,  5,  0,  0,  0,  0,  1,  0, 5'b00111, 2'b01, 2'b00, 2'b00};
        vt[2]  = '{3,  9,  0,  0,  9,  0,  0,  0,  0,  1,  0, 5'b00111, 2'b01, 2'b00, 2'b00};
        vt[3]  = '{0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  0, 5'b11111, 2'b00, 2'b00, 2'b00};
        vt[4]  = '{5,  0,  0,  0,  5,  0,  0,  0,  0,  0,  0, 5'b11111, 2'b00, 2'b00, 2'b00};
        vt[5]  = '{5,  0,  0,  0,  5,  0,  0,  0,  0,  1,  1, 5'b11111, 2'b11, 2'b00, 2'b00};
        vt[6]  = '{0,  0,  7,  0,  0,  7,  7,  1,  1,  0,  0, 5'b11111, 2'b00, 2'b10, 2'b00};
        vt[7]  = '{0,  0,  7,  0,  0,  0,  0,  1,  1,  0,  0, 5'b11111, 2'b00, 2'b00, 2'b00};
        vt[8]  = '{0,  0,  0,  0,  0,  0,  0,  1,  1,  0,  0, 5'b11111, 2'b00, 2'b00, 2'b00};
        vt[9]  = '{0,  0,  0, 12,  0, 12, 12,  0,  1,  0,  0, 5'b11111, 2'b00, 2'b00, 2'b01};
        vt[10] = '{0,  0,  6,  4,  0,  4,  6,  1,  1,  0,  0, 5'b11111, 2'b00, 2'b01, 2'b10};
        vt[11] = '{0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  1, 5'b11111, 2'b11, 2'b00, 2'b00};

        // Reset state, with inputs that would otherwise forward and stall
        clear_inputs();
        rst_n = 1'b0;
        RdM = 7; Rs1E = 7; RegWriteM = 1'b1; PCSrcE = 1'b1;
        #12;
        chk("reset_en", en_bus(), 5'b00000);
        chk("reset_clr", {ClrD, ClrE}, 2'b00);
        chk("reset_fwd", {ForwardAE, ForwardBE}, 4'b0000);
        chk("reset_cnt", {stall_cycles, flush_count}, 64'd0);

        // First cycle after release: load-use bubble
        cyc();
        rst_n = 1'b1;
        clear_inputs();
        RdE = 5; ResultSrcE0 = 1'b1; Rs1D = 5;
        #1;
        chk("lu_en", en_bus(), 5'b00111);
        chk("lu_clr", {ClrD, ClrE}, 2'b01);
        chk("lu_stall_before", stall_cycles, 32'd0);
        cyc();
        clear_inputs();
        #1;
        chk("lu_stall_after", stall_cycles, 32'd1);

        // Load-use together with taken branch: flush wins
        RdE = 5; ResultSrcE0 = 1'b1; Rs1D = 5; PCSrcE = 1'b1;
        #1;
        chk("lubr_en", en_bus(), 5'b11111);
        chk("lubr_clr", {ClrD, ClrE}, 2'b11);
        sc = stall_cycles; fc = flush_count;
        cyc();
        clear_inputs();
        #1;
        chk("lubr_flush", flush_count, fc + 32'd1);
        chk("lubr_stall", stall_cycles, sc);

        // Combinational RUN-state vectors
        for (int i = 0; i < 12; i++) begin
            cyc();
            clear_inputs();
            Rs1D = vt[i].rs1d; Rs2D = vt[i].rs2d; Rs1E = vt[i].rs1e; Rs2E = vt[i].rs2e;
            RdE = vt[i].rde; RdM = vt[i].rdm; RdW = vt[i].rdw;
            RegWriteM = vt[i].rwm; RegWriteW = vt[i].rww;
            ResultSrcE0 = vt[i].lde; PCSrcE = vt[i].br;
            #1;
            chk($sformatf("vec%0d_en", i), en_bus(), vt[i].en);
            chk($sformatf("vec%0d_clr", i), {ClrD, ClrE}, vt[i].clr);
            chk($sformatf("vec%0d_fwd", i), {ForwardAE, ForwardBE}, {vt[i].fa, vt[i].fb});
        end

        // Data miss held 5 cycles with a branch pending: freeze, then the flush is taken on resume
        cyc();
        clear_inputs();
        #1;
        sc = stall_cycles; fc = flush_count;
        for (int k = 0; k < 5; k++) begin
            dmiss_m = 1'b1; PCSrcE = 1'b1; dmem_ready = (k == 4);
            #1;
            chk($sformatf("dmiss_c%0d_en", k), en_bus(), 5'b00000);
            chk($sformatf("dmiss_c%0d_clr", k), {ClrD, ClrE}, 2'b00);
            cyc();
        end
        dmiss_m = 1'b0; dmem_ready = 1'b0;
        #1;
        chk("dmiss_resume_en", en_bus(), 5'b11111);
        chk("dmiss_resume_clr", {ClrD, ClrE}, 2'b11);
        chk("dmiss_stall", stall_cycles, sc + 32'd5);
        chk("dmiss_flush", flush_count, fc);

        // Dual miss: data first, then instruction; stray data pulse during the I wait is ignored
        cyc();
        clear_inputs();
        #1;
        sc = stall_cycles;
        for (int c = 0; c < 7; c++) begin
            imiss_f = 1'b1;
            dmiss_m = (c <= 3);
            dmem_ready = (c == 3) || (c == 5);
            imem_ready = (c == 6);
            #1;
            chk($sformatf("dual_c%0d_en", c), en_bus(), 5'b00000);
            cyc();
        end
        clear_inputs();
        #1;
        chk("dual_resume_en", en_bus(), 5'b11111);
        chk("dual_stall", stall_cycles, sc + 32'd7);

        // Reset while waiting for an instruction fill
        imiss_f = 1'b1;
        cyc();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_en", en_bus(), 5'b00000);
        chk("rst_mid_cnt", {stall_cycles, flush_count}, 64'd0);
        cyc();
        rst_n = 1'b1;
        imiss_f = 1'b0;
        #1;
        chk("rst_release_en", en_bus(), 5'b11111);
        chk("rst_release_clr", {ClrD, ClrE}, 2'b00);

        // Randomized run against a fill-queue model
        cyc();
        rst_n = 1'b0;
        clear_inputs();
        cyc();
        rst_n = 1'b1;
        wq.delete();
        m_stall = 0; m_flush = 0;
        d_on = 0; d_done = 0; i_on = 0; i_done = 0; d_cnt = 0; i_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            cyc();
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            ResultSrcE0 = 1'($urandom); PCSrcE = ($urandom_range(0, 3) == 0);
            cache_step(d_on, d_done, d_cnt, dmiss_m, dmem_ready);
            cache_step(i_on, i_done, i_cnt, imiss_f, imem_ready);
            #1;
            frozen = (wq.size() != 0) || dmiss_m || imiss_f;
            lu = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
            if (frozen)      begin exp_en = 5'b00000; exp_clr = 2'b00; end
            else if (PCSrcE) begin exp_en = 5'b11111; exp_clr = 2'b11; end
            else if (lu)     begin exp_en = 5'b00111; exp_clr = 2'b01; end
            else             begin exp_en = 5'b11111; exp_clr = 2'b00; end
            chk($sformatf("rnd%0d_en", n), {en_bus(), ClrD, ClrE}, {exp_en, exp_clr});
            chk($sformatf("rnd%0d_fwd", n), {ForwardAE, ForwardBE}, {fsel(Rs1E), fsel(Rs2E)});
            chk($sformatf("rnd%0d_cnt", n), {stall_cycles, flush_count}, {m_stall, m_flush});
            if (!exp_en[4]) m_stall++;
            if (!frozen && PCSrcE) m_flush++;
            if (wq.size() == 0) begin
                if (dmiss_m)      wq.push_back(1'b1);
                else if (imiss_f) wq.push_back(1'b0);
            end else if (wq[0] && dmem_ready) begin
                void'(wq.pop_front());
                if (imiss_f) wq.push_back(1'b0);
            end else if (!wq[0] && imem_ready) begin
                void'(wq.pop_front());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
